// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - start/ready/done handshake and operand/product bundle for the shift-add multiplier
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 64
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   in_ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, a, b,
        input  in_ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output in_ready, busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative signed/unsigned shift-add multiplier, one multiplier bit per clock
// Optional early termination on zero remaining multiplier bits: define SEQ_MULT_EARLY_TERM_EN.
module seq_shift_add_multiplier #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_shift_add_multiplier_if.slave io
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   mreg_q, mreg_d;
    logic [PW-1:0]      acc_b_q, acc_b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Magnitudes are taken as unsigned WIDTH-bit values so -2^(W-1) maps exactly to 2^(W-1).
    always_comb begin
        mag_a = (io.signed_mode && io.a[WIDTH-1]) ? -io.a : io.a;
        mag_b = (io.signed_mode && io.b[WIDTH-1]) ? -io.b : io.b;
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mreg_d    = mreg_q;
        acc_b_d   = acc_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    sign_d    = io.signed_mode & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
                    mreg_d    = mag_a;
                    acc_b_d   = {{WIDTH{1'b0}}, mag_b};
                    acc_d     = '0;
                    product_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = mreg_q[0] ? (acc_q + acc_b_q) : acc_q;
                mreg_d  = mreg_q >> 1;
                acc_b_d = acc_b_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end
`ifdef SEQ_MULT_EARLY_TERM_EN
                // Remaining multiplier bits are all zero, so no further additions can occur.
                if (mreg_d == '0) begin
                    state_d = S_FINISH;
                end
`endif
            end
            S_FINISH: begin
                product_d = sign_q ? -acc_q : acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = !in_ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            mreg_q     <= '0;
            acc_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mreg_q     <= mreg_d;
            acc_b_q    <= acc_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign io.in_ready = in_ready_q;
    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.product  = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - scoreboard bench for WIDTH=8 and WIDTH=64 multiplier instances
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst64 = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_add_multiplier_if #(.WIDTH(8))  m8();
    seq_shift_add_multiplier_if #(.WIDTH(64)) m64();

    seq_shift_add_multiplier #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .io(m8));
    seq_shift_add_multiplier #(.WIDTH(64)) u64 (.clk(clk), .rst(rst64), .io(m64));

    typedef struct {
        logic [127:0] prod;
        int           due;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    exp_t e8, e64;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [127:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int p;
        if (sm) p = int'($signed(a)) * int'($signed(b));
        else    p = int'({24'b0, a}) * int'({24'b0, b});
        return {112'b0, p[15:0]};
    endfunction

    function automatic logic [127:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic sm);
        logic [127:0] sa, sb;
        sa = sm ? {{64{a[63]}}, a} : {64'b0, a};
        sb = sm ? {{64{b[63]}}, b} : {64'b0, b};
        return sa * sb;
    endfunction

    // Cycles from the accepting edge to the edge that raises done.
    function automatic int lat_of(input logic [127:0] mag, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
        if (n == 0) n = 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        return n + 1;
`else
        return w + 1;
`endif
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit push);
        int k = 0;
        logic [7:0] mag;
        @(negedge clk);
        while (!m8.in_ready && k < 500) begin @(negedge clk); k++; end
        if (!m8.in_ready) chk("ready8_timeout", 0, 1);
        m8.a = a; m8.b = b; m8.signed_mode = sm; m8.start = 1'b1;
        @(posedge clk); #1;
        m8.start = 1'b0;
        m8.a = 8'($urandom); m8.b = 8'($urandom); m8.signed_mode = 1'($urandom_range(0, 1));
        mag = (sm && a[7]) ? (~a + 8'd1) : a;
        if (push) q8.push_back('{ref8(a, b, sm), cyc + lat_of({120'b0, mag}, 8)});
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sm);
        int k = 0;
        logic [63:0] mag;
        @(negedge clk);
        while (!m64.in_ready && k < 500) begin @(negedge clk); k++; end
        if (!m64.in_ready) chk("ready64_timeout", 0, 1);
        m64.a = a; m64.b = b; m64.signed_mode = sm; m64.start = 1'b1;
        @(posedge clk); #1;
        m64.start = 1'b0;
        m64.a = {$urandom, $urandom}; m64.b = {$urandom, $urandom};
        mag = (sm && a[63]) ? (~a + 64'd1) : a;
        q64.push_back('{ref64(a, b, sm), cyc + lat_of({64'b0, mag}, 64)});
    endtask

    always @(negedge clk) begin
        if (!rst8 && m8.done) begin
            if (q8.size() == 0) chk("spurious_done8", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("prod8", m8.product, e8.prod);
                chk("lat8", cyc, e8.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst64 && m64.done) begin
            if (q64.size() == 0) chk("spurious_done64", 1, 0);
            else begin
                e64 = q64.pop_front();
                chk("prod64", m64.product, e64.prod);
                chk("lat64", cyc, e64.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        m8.start = 0;  m8.a = 0;  m8.b = 0;  m8.signed_mode = 0;
        m64.start = 0; m64.a = 0; m64.b = 0; m64.signed_mode = 0;
        repeat (3) @(posedge clk);
        #1; rst8 = 0; rst64 = 0;
        @(negedge clk);
        chk("rst_in_ready8", m8.in_ready, 1);
        chk("rst_busy8", m8.busy, 0);
        chk("rst_done8", m8.done, 0);
        chk("rst_product8", m8.product, 0);
        chk("rst_in_ready64", m64.in_ready, 1);
        chk("rst_product64", m64.product, 0);

        // 255*255 unsigned: in_ready low for the full 9-cycle operation
        issue8(8'd255, 8'd255, 1'b0, 1);
        n = 0;
        do begin
            @(negedge clk);
            if (!m8.in_ready) begin
                n++;
                if (n == 1) chk("busy_in_run8", m8.busy, 1);
            end
        end while (!m8.in_ready && n < 100);
        chk("ready_low8", n, 9);

        issue8(8'h80, 8'h80, 1'b1, 1);
        issue8(8'hFF, 8'd127, 1'b1, 1);
        issue8(8'd0, 8'hFB, 1'b1, 1);
        for (int i = 0; i < 20; i++)
            issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);

        // start during RUN with other operands must be ignored
        issue8(8'd11, 8'd13, 1'b0, 1);
        repeat (3) @(negedge clk);
        m8.a = 8'd99; m8.b = 8'd99; m8.start = 1'b1;
        @(negedge clk);
        m8.start = 1'b0;

        // reset sampled on RUN edge 3 aborts the operation
        issue8(8'd200, 8'd200, 1'b0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk("abort_in_ready8", m8.in_ready, 1);
        chk("abort_busy8", m8.busy, 0);
        chk("abort_done8", m8.done, 0);
        chk("abort_product8", m8.product, 0);
        issue8(8'd3, 8'd5, 1'b0, 1);

        issue64(64'd1, 64'd7, 1'b0);
        issue64(64'h8000_0000_0000_0000, 64'd3, 1'b0);
        issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        for (int i = 0; i < 200; i++)
            issue64({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        k = 0;
        while ((q8.size() != 0 || q64.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain64", q64.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
